// File: rtl/debug_unit.sv
// UART-driven debug unit: loads instruction memory, runs or single-steps the pipeline,
// then dumps the register file (and data memory when DUNIT_MEM_DUMP_EN is defined) over tx.
module debug_unit #(
  parameter int NB_REG      = 32,
  parameter int N_REGS      = 32,
  parameter int N_MEM_WORDS = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_done,
  output logic              o_dunit_clk_en,
  output logic              o_dunit_reset_pc,
  output logic              o_dunit_w_mem,
  output logic [NB_REG-1:0] o_dunit_addr,
  output logic [NB_REG-1:0] o_dunit_data_if,
  input  logic [NB_REG-1:0] i_dunit_reg,
  input  logic [NB_REG-1:0] i_dunit_mem_data,
  input  logic              i_halt
);

  typedef enum logic [3:0] {
    IDLE, LD_CNT, LD_BYTE, LD_WRITE, RUN, STEP,
    DMP_ADDR, DMP_CAPT, DMP_SEND, DMP_WAIT
  } state_t;

`ifdef DUNIT_MEM_DUMP_EN
  localparam int N_WORDS = N_REGS + N_MEM_WORDS;
`else
  localparam int N_WORDS = N_REGS;
  logic unused_mem;
  assign unused_mem = ^i_dunit_mem_data;
`endif
  localparam int DCW = $clog2(N_WORDS + 1);

  state_t            state, state_n;
  logic              halted, halted_n;
  logic [7:0]        word_idx, word_idx_n;
  logic [7:0]        word_cnt, word_cnt_n;
  logic [7:0]        last_idx;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [NB_REG-1:0] asm_word, asm_word_n;
  logic [DCW-1:0]    dcnt, dcnt_n;
  logic [1:0]        tx_idx, tx_idx_n;
  logic [NB_REG-1:0] lat_word, lat_word_n;
  logic              mem_phase;

  logic [7:0]        tx_data_n;
  logic              tx_start_n, clk_en_n, reset_pc_n, w_mem_n;
  logic [NB_REG-1:0] addr_n, data_if_n;

  // Word count 0 encodes 256, so the last index wraps naturally to 255.
  assign last_idx = word_cnt - 8'd1;

`ifdef DUNIT_MEM_DUMP_EN
  assign mem_phase = (dcnt >= DCW'(N_REGS));
`else
  assign mem_phase = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    halted_n   = halted;
    word_idx_n = word_idx;
    word_cnt_n = word_cnt;
    byte_idx_n = byte_idx;
    asm_word_n = asm_word;
    dcnt_n     = dcnt;
    tx_idx_n   = tx_idx;
    lat_word_n = lat_word;
    tx_data_n  = o_tx_data;
    addr_n     = o_dunit_addr;
    data_if_n  = o_dunit_data_if;
    tx_start_n = 1'b0;
    clk_en_n   = 1'b0;
    reset_pc_n = 1'b0;
    w_mem_n    = 1'b0;

    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            8'h4C: state_n = LD_CNT;
            8'h43: if (!halted) begin
              state_n  = RUN;
              clk_en_n = 1'b1;
              dcnt_n   = '0;
            end
            8'h53: if (!halted) begin
              state_n  = STEP;
              clk_en_n = 1'b1;
              dcnt_n   = '0;
            end
            default: ;
          endcase
        end
      end
      LD_CNT: begin
        if (i_rx_valid) begin
          word_cnt_n = i_rx_data;
          word_idx_n = '0;
          byte_idx_n = '0;
          asm_word_n = '0;
          state_n    = LD_BYTE;
        end
      end
      LD_BYTE: begin
        if (i_rx_valid) begin
          asm_word_n[{byte_idx, 3'b000} +: 8] = i_rx_data;
          byte_idx_n = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            w_mem_n   = 1'b1;
            addr_n    = NB_REG'({word_idx, 2'b00});
            data_if_n = asm_word_n;
            state_n   = LD_WRITE;
          end
        end
      end
      LD_WRITE: begin
        word_idx_n = word_idx + 8'd1;
        if (word_idx == last_idx) begin
          reset_pc_n = 1'b1;
          halted_n   = 1'b0;
          state_n    = IDLE;
        end else begin
          state_n = LD_BYTE;
        end
      end
      RUN: begin
        if (i_halt) begin
          halted_n = 1'b1;
          state_n  = DMP_ADDR;
        end else begin
          clk_en_n = 1'b1;
        end
      end
      STEP: begin
        if (i_halt) halted_n = 1'b1;
        state_n = DMP_ADDR;
      end
      // Address is registered here; the read data is valid during DMP_CAPT.
      DMP_ADDR: begin
        if (mem_phase) addr_n = NB_REG'(dcnt - DCW'(N_REGS)) << 2;
        else           addr_n = NB_REG'(dcnt);
        state_n = DMP_CAPT;
      end
      DMP_CAPT: begin
        lat_word_n = mem_phase ? i_dunit_mem_data : i_dunit_reg;
        tx_idx_n   = '0;
        state_n    = DMP_SEND;
      end
      DMP_SEND: begin
        tx_start_n = 1'b1;
        tx_data_n  = lat_word[{tx_idx, 3'b000} +: 8];
        state_n    = DMP_WAIT;
      end
      DMP_WAIT: begin
        if (i_tx_done) begin
          if (tx_idx == 2'd3) begin
            tx_idx_n = '0;
            if (dcnt == DCW'(N_WORDS - 1)) begin
              dcnt_n  = '0;
              state_n = IDLE;
            end else begin
              dcnt_n  = dcnt + DCW'(1);
              state_n = DMP_ADDR;
            end
          end else begin
            tx_idx_n = tx_idx + 2'd1;
            state_n  = DMP_SEND;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state            <= IDLE;
      halted           <= 1'b0;
      word_idx         <= '0;
      word_cnt         <= '0;
      byte_idx         <= '0;
      asm_word         <= '0;
      dcnt             <= '0;
      tx_idx           <= '0;
      lat_word         <= '0;
      o_tx_data        <= '0;
      o_tx_start       <= 1'b0;
      o_dunit_clk_en   <= 1'b0;
      o_dunit_reset_pc <= 1'b0;
      o_dunit_w_mem    <= 1'b0;
      o_dunit_addr     <= '0;
      o_dunit_data_if  <= '0;
    end else begin
      state            <= state_n;
      halted           <= halted_n;
      word_idx         <= word_idx_n;
      word_cnt         <= word_cnt_n;
      byte_idx         <= byte_idx_n;
      asm_word         <= asm_word_n;
      dcnt             <= dcnt_n;
      tx_idx           <= tx_idx_n;
      lat_word         <= lat_word_n;
      o_tx_data        <= tx_data_n;
      o_tx_start       <= tx_start_n;
      o_dunit_clk_en   <= clk_en_n;
      o_dunit_reset_pc <= reset_pc_n;
      o_dunit_w_mem    <= w_mem_n;
      o_dunit_addr     <= addr_n;
      o_dunit_data_if  <= data_if_n;
    end
  end

endmodule

// File: tb/tb_debug_unit.sv
// Directed self-checking bench for debug_unit: load, step, run/halt, ignore rules and reset.
module tb_debug_unit;
  localparam int N_REGS = 32;
`ifdef DUNIT_MEM_DUMP_EN
  localparam int EXP = 256;
`else
  localparam int EXP = 128;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_done = 1'b0;
  logic        halt = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start, clk_en, reset_pc, w_mem;
  logic [31:0] addr, data_if, reg_data, mem_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Pipeline model: register k reads k+0x100, memory byte address a reads 0xA0000000|a.
  assign reg_data = addr + 32'h100;
  assign mem_data = 32'hA000_0000 | addr;

  debug_unit dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_dunit_clk_en(clk_en), .o_dunit_reset_pc(reset_pc), .o_dunit_w_mem(w_mem),
    .o_dunit_addr(addr), .o_dunit_data_if(data_if),
    .i_dunit_reg(reg_data), .i_dunit_mem_data(mem_data), .i_halt(halt)
  );

  int          cyc = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          rpc_cyc_q[$];
  logic [7:0]  tx_q[$];
  int          clken_n = 0, clken_first = 0, clken_last = 0;
  int          busy = 0, timer = 0, busy_viol = 0, halt_at = 0;

  // Monitor and UART transmitter model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      tx_done = 1'b0;
      if (w_mem) begin
        wr_addr_q.push_back(addr);
        wr_data_q.push_back(data_if);
        wr_cyc_q.push_back(cyc);
      end
      if (reset_pc) rpc_cyc_q.push_back(cyc);
      if (clk_en) begin
        clken_n++;
        if (clken_n == 1) clken_first = cyc;
        clken_last = cyc;
        if (halt_at != 0 && clken_n == halt_at) halt = 1'b1;
      end
      if (tx_start) begin
        tx_q.push_back(tx_data);
        if (busy != 0) busy_viol++;
        busy = 1;
        timer = 3;
      end else if (busy != 0) begin
        timer--;
        if (timer == 0) begin
          tx_done = 1'b1;
          busy = 0;
        end
      end
    end
  end

  function automatic logic [7:0] exp_byte(int i);
    int k;
    logic [31:0] w;
    k = i / 4;
    if (k < N_REGS) w = k + 32'h100;
    else            w = 32'hA000_0000 | ((k - N_REGS) * 4);
    return w[(i % 4) * 8 +: 8];
  endfunction

  function automatic int count_bad();
    int bad = 0;
    for (int i = 0; i < tx_q.size(); i++)
      if (tx_q[i] !== exp_byte(i)) bad++;
    return bad;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(1);
  endtask

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rpc_cyc_q.delete(); tx_q.delete();
    clken_n = 0; clken_first = 0; clken_last = 0;
  endtask

  task automatic wait_tx(int n, int budget, output bit ok);
    int c = 0;
    while (tx_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    ok = (tx_q.size() >= n);
    tick(20);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    checks++; if (clk_en !== 1'b0) begin failures++; $display("FAIL rst_clk_en got=%b exp=0", clk_en); end
    checks++; if (reset_pc !== 1'b0) begin failures++; $display("FAIL rst_reset_pc got=%b exp=0", reset_pc); end
    checks++; if (w_mem !== 1'b0) begin failures++; $display("FAIL rst_w_mem got=%b exp=0", w_mem); end
    checks++; if (addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", addr); end
    checks++; if (data_if !== 32'h0) begin failures++; $display("FAIL rst_data_if got=%h exp=0", data_if); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_load_one();
    clear_mon();
    send(8'h4C); send(8'h01); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    tick(4);
    checks++; if (wr_addr_q.size() !== 1) begin failures++; $display("FAIL load1_wr_count got=%0d exp=1", wr_addr_q.size()); end
    if (wr_addr_q.size() >= 1) begin
      checks++; if (wr_addr_q[0] !== 32'h0) begin failures++; $display("FAIL load1_addr got=%h exp=0", wr_addr_q[0]); end
      checks++; if (wr_data_q[0] !== 32'h1234_5678) begin failures++; $display("FAIL load1_data got=%h exp=12345678", wr_data_q[0]); end
    end
    checks++; if (rpc_cyc_q.size() !== 1) begin failures++; $display("FAIL load1_rpc_count got=%0d exp=1", rpc_cyc_q.size()); end
    if (rpc_cyc_q.size() >= 1 && wr_cyc_q.size() >= 1) begin
      checks++; if (rpc_cyc_q[0] !== wr_cyc_q[0] + 1) begin failures++; $display("FAIL load1_rpc_timing got=%0d exp=%0d", rpc_cyc_q[0], wr_cyc_q[0] + 1); end
    end
  endtask

  task automatic test_load_two();
    clear_mon();
    send(8'h4C); send(8'h02);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    tick(4);
    checks++; if (wr_addr_q.size() !== 2) begin failures++; $display("FAIL load2_wr_count got=%0d exp=2", wr_addr_q.size()); end
    if (wr_addr_q.size() >= 2) begin
      checks++; if (wr_addr_q[0] !== 32'h0) begin failures++; $display("FAIL load2_addr0 got=%h exp=0", wr_addr_q[0]); end
      checks++; if (wr_addr_q[1] !== 32'h4) begin failures++; $display("FAIL load2_addr1 got=%h exp=4", wr_addr_q[1]); end
      checks++; if (wr_data_q[0] !== 32'h0403_0201) begin failures++; $display("FAIL load2_data0 got=%h exp=04030201", wr_data_q[0]); end
      checks++; if (wr_data_q[1] !== 32'hDDCC_BBAA) begin failures++; $display("FAIL load2_data1 got=%h exp=ddccbbaa", wr_data_q[1]); end
    end
    checks++; if (rpc_cyc_q.size() !== 1) begin failures++; $display("FAIL load2_rpc_count got=%0d exp=1", rpc_cyc_q.size()); end
    if (rpc_cyc_q.size() >= 1 && wr_cyc_q.size() >= 2) begin
      checks++; if (rpc_cyc_q[0] !== wr_cyc_q[1] + 1) begin failures++; $display("FAIL load2_rpc_timing got=%0d exp=%0d", rpc_cyc_q[0], wr_cyc_q[1] + 1); end
    end
  endtask

  task automatic test_step();
    bit ok;
    logic [31:0] first;
    clear_mon();
    send(8'h53);
    wait_tx(EXP, 8000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL step_timeout got=%0d bytes exp=%0d", tx_q.size(), EXP); end
    checks++; if (clken_n !== 1) begin failures++; $display("FAIL step_clk_en_cycles got=%0d exp=1", clken_n); end
    checks++; if (tx_q.size() !== EXP) begin failures++; $display("FAIL step_byte_count got=%0d exp=%0d", tx_q.size(), EXP); end
    if (tx_q.size() >= 4) begin
      first = {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
      checks++; if (first !== 32'h0000_0100) begin failures++; $display("FAIL step_first_word got=%h exp=00000100", first); end
    end
    checks++; if (count_bad() !== 0) begin failures++; $display("FAIL step_content got=%0d bad bytes exp=0", count_bad()); end
    checks++; if (busy_viol !== 0) begin failures++; $display("FAIL step_start_before_done got=%0d exp=0", busy_viol); end
  endtask

  task automatic test_ignore();
    bit ok;
    int c = 0;
    clear_mon();
    send(8'h41);
    tick(10);
    checks++; if (tx_q.size() !== 0 || clken_n !== 0) begin failures++; $display("FAIL ignore_41 got tx=%0d clk_en=%0d exp=0/0", tx_q.size(), clken_n); end
    send(8'h53);
    while (tx_q.size() < 5 && c < 200) begin tick(1); c++; end
    send(8'h4C); send(8'h43); send(8'h53); send(8'h01);
    wait_tx(EXP, 8000, ok);
    checks++; if (tx_q.size() !== EXP) begin failures++; $display("FAIL ignore_dump_bytes got=%0d exp=%0d", tx_q.size(), EXP); end
    checks++; if (clken_n !== 1) begin failures++; $display("FAIL ignore_dump_clk_en got=%0d exp=1", clken_n); end
    checks++; if (wr_addr_q.size() !== 0) begin failures++; $display("FAIL ignore_dump_writes got=%0d exp=0", wr_addr_q.size()); end
    checks++; if (count_bad() !== 0) begin failures++; $display("FAIL ignore_dump_content got=%0d bad bytes exp=0", count_bad()); end
  endtask

  task automatic test_run();
    bit ok;
    clear_mon();
    halt_at = 20;
    send(8'h43);
    wait_tx(EXP, 8000, ok);
    checks++; if (clken_n !== 20) begin failures++; $display("FAIL run_clk_en_cycles got=%0d exp=20", clken_n); end
    checks++; if (clken_last - clken_first !== 19) begin failures++; $display("FAIL run_clk_en_contiguous got=%0d exp=19", clken_last - clken_first); end
    checks++; if (tx_q.size() !== EXP) begin failures++; $display("FAIL run_dump_bytes got=%0d exp=%0d", tx_q.size(), EXP); end
    checks++; if (count_bad() !== 0) begin failures++; $display("FAIL run_dump_content got=%0d bad bytes exp=0", count_bad()); end
    halt_at = 0;
    clear_mon();
    send(8'h43);
    send(8'h53);
    tick(60);
    checks++; if (clken_n !== 0 || tx_q.size() !== 0) begin failures++; $display("FAIL run_halted_ignore got clk_en=%0d tx=%0d exp=0/0", clken_n, tx_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    int c = 0;
    halt = 1'b0;
    clear_mon();
    send(8'h4C); send(8'h01); send(8'h11); send(8'h22); send(8'h33);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if ({tx_start, tx_data, clk_en, reset_pc, w_mem, addr, data_if} !== '0) begin failures++; $display("FAIL midload_outputs got=%b exp=0", {tx_start, tx_data, clk_en, reset_pc, w_mem, addr, data_if}); end
    send(8'h44);
    tick(4);
    checks++; if (wr_addr_q.size() !== 0) begin failures++; $display("FAIL midload_no_write got=%0d exp=0", wr_addr_q.size()); end
    send(8'h4C); send(8'h01); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    tick(4);
    checks++; if (wr_addr_q.size() !== 1) begin failures++; $display("FAIL reload_wr_count got=%0d exp=1", wr_addr_q.size()); end
    if (wr_addr_q.size() >= 1) begin
      checks++; if (wr_data_q[0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL reload_data got=%h exp=deadbeef", wr_data_q[0]); end
      checks++; if (wr_addr_q[0] !== 32'h0) begin failures++; $display("FAIL reload_addr got=%h exp=0", wr_addr_q[0]); end
    end
    checks++; if (rpc_cyc_q.size() !== 1) begin failures++; $display("FAIL reload_rpc_count got=%0d exp=1", rpc_cyc_q.size()); end
    clear_mon();
    send(8'h53);
    while (tx_q.size() < 8 && c < 400) begin tick(1); c++; end
    checks++; if (tx_q.size() < 8) begin failures++; $display("FAIL middump_timeout got=%0d exp>=8", tx_q.size()); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if ({tx_start, clk_en, reset_pc, w_mem, addr} !== '0) begin failures++; $display("FAIL middump_outputs got=%b exp=0", {tx_start, clk_en, reset_pc, w_mem, addr}); end
    n = tx_q.size();
    tick(60);
    checks++; if (tx_q.size() !== n) begin failures++; $display("FAIL middump_stopped got=%0d exp=%0d", tx_q.size(), n); end
  endtask

  initial begin
    test_reset();
    test_load_one();
    test_load_two();
    test_step();
    test_ignore();
    test_run();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
